// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite draw engine: fetches sprite rows and XORs set bits onto the framebuffer.
// Optional macro CHIP8_SPRITE_CLIP_EN clips pixels past the right/bottom edge instead of wrapping.
module chip8_sprite_draw #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int FB_READ_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] i_addr,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_readdata,
  output logic [5:0]  fb_addr_x,
  output logic [4:0]  fb_addr_y,
  output logic        fb_writedata,
  output logic        fb_WE,
  input  logic        fb_readdata,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_PIX, S_WR, S_DONE
  } state_t;

  localparam logic [1:0] MEM_LAST = 2'(MEM_READ_LATENCY - 1);
  localparam logic [1:0] FB_LAST  = 2'(FB_READ_LATENCY - 1);

  state_t      state;
  logic [5:0]  x0;
  logic [4:0]  y0;
  logic [3:0]  n_q;
  logic [3:0]  row;
  logic [11:0] base;
  logic [2:0]  col;
  logic [1:0]  cnt;
  logic [7:0]  sprite_q;
  logic        wd_q;

  logic        cur_on;
  logic        nx_on;
  logic        lat_on;
  logic        last_row;
  logic        adv;
  logic [2:0]  col_nx;
  logic        unused_bits;

  assign unused_bits = ^{x_in[7:6], y_in[7:5]};

  // A pixel is drawn when its sprite bit is set (and, when clipping, it lies on screen).
  function automatic logic pix_on(
    input logic [7:0] b,
    input logic [2:0] c,
    input logic [3:0] r,
    input logic [5:0] xs,
    input logic [4:0] ys
  );
`ifdef CHIP8_SPRITE_CLIP_EN
    logic [6:0] xsum;
    logic [5:0] ysum;
    xsum = {1'b0, xs} + {4'b0, c};
    ysum = {1'b0, ys} + {2'b0, r};
    return b[~c] & ~xsum[6] & ~ysum[5];
`else
    logic unused_coord;
    unused_coord = ^{r, xs, ys};
    return b[~c] | (unused_coord & 1'b0);
`endif
  endfunction

  assign col_nx   = col + 3'd1;
  assign cur_on   = pix_on(sprite_q, col, row, x0, y0);
  assign nx_on    = pix_on(sprite_q, col_nx, row, x0, y0);
  assign lat_on   = pix_on(mem_readdata, 3'd0, row, x0, y0);
  assign last_row = ({1'b0, row} + 5'd1) >= {1'b0, n_q};
  assign adv      = (state == S_WR) |
                    ((state == S_PIX) & ~cur_on);

  // New pixel is the inverse of what the framebuffer returns during the write cycle.
  assign fb_writedata = (state == S_WR) ? ~fb_readdata : wd_q;

  // Draw sequencer: row fetch, per-column read-modify-write, completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      x0        <= '0;
      y0        <= '0;
      n_q       <= '0;
      row       <= '0;
      base      <= '0;
      col       <= '0;
      cnt       <= '0;
      sprite_q  <= '0;
      wd_q      <= 1'b0;
      mem_addr  <= '0;
      fb_addr_x <= '0;
      fb_addr_y <= '0;
      fb_WE     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
    end else begin
      done  <= 1'b0;
      fb_WE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x0        <= x_in[5:0];
            y0        <= y_in[4:0];
            n_q       <= n_in;
            base      <= i_addr;
            row       <= '0;
            cnt       <= '0;
            collision <= 1'b0;
            busy      <= 1'b1;
            if (n_in == 4'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              mem_addr <= i_addr;
            end
          end
        end
        S_FETCH: begin
          if (cnt == MEM_LAST) begin
            cnt   <= '0;
            state <= S_LATCH;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_LATCH: begin
          sprite_q <= mem_readdata;
          col      <= '0;
          cnt      <= '0;
          state    <= S_PIX;
          if (lat_on) begin
            fb_addr_x <= x0;
            fb_addr_y <= y0 + {1'b0, row};
          end
        end
        S_PIX: begin
          if (cur_on) begin
            if (cnt == FB_LAST) begin
              state <= S_WR;
              fb_WE <= 1'b1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_WR: begin
          collision <= collision | fb_readdata;
          wd_q      <= ~fb_readdata;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (adv) begin
        cnt <= '0;
        if (col != 3'd7) begin
          col   <= col_nx;
          state <= S_PIX;
          if (nx_on) begin
            fb_addr_x <= x0 + {3'b0, col_nx};
            fb_addr_y <= y0 + {1'b0, row};
          end
        end else if (!last_row) begin
          row      <= row + 4'd1;
          mem_addr <= base + {8'b0, row} + 12'd1;
          state    <= S_FETCH;
        end else begin
          state <= S_DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Bench for chip8_sprite_draw: memory/framebuffer models, reference draw model,
// per-cycle write/done/busy checker and directed plus random draws.
module tb_chip8_sprite_draw;

  localparam int ML = 1;
  localparam int FL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [3:0]  n_in;
  logic [11:0] i_addr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_readdata;
  logic [5:0]  fb_addr_x;
  logic [4:0]  fb_addr_y;
  logic        fb_writedata;
  logic        fb_WE;
  logic        fb_readdata;
  logic        busy;
  logic        done;
  logic        collision;

  always #5 clk = ~clk;

  chip8_sprite_draw #(
    .MEM_READ_LATENCY(ML),
    .FB_READ_LATENCY (FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x_in        (x_in),
    .y_in        (y_in),
    .n_in        (n_in),
    .i_addr      (i_addr),
    .mem_addr    (mem_addr),
    .mem_readdata(mem_readdata),
    .fb_addr_x   (fb_addr_x),
    .fb_addr_y   (fb_addr_y),
    .fb_writedata(fb_writedata),
    .fb_WE       (fb_WE),
    .fb_readdata (fb_readdata),
    .busy        (busy),
    .done        (done),
    .collision   (collision)
  );

  // Main memory with ML-cycle read latency
  bit   [7:0] mem [4096];
  logic [7:0] mpipe [ML];
  always @(posedge clk) begin
    mpipe[0] <= mem[mem_addr];
    for (int k = 1; k < ML; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mem_readdata = mpipe[ML-1];

  // Framebuffer with FL-cycle read latency
  bit fbm [32][64];
  bit fpipe [FL];
  always @(posedge clk) begin
    if (fb_WE) fbm[fb_addr_y][fb_addr_x] <= fb_writedata;
    fpipe[0] <= fbm[fb_addr_y][fb_addr_x];
    for (int k = 1; k < FL; k++) fpipe[k] <= fpipe[k-1];
  end
  assign fb_readdata = fpipe[FL-1];

  // Reference model state
  typedef struct { int x; int y; int d; } wr_t;
  wr_t q[$];
  bit  ref_fb [32][64];
  int  exp_cycles;
  int  exp_coll;
  int  exp_writes;
  bit  act;
  bit  mon_en;
  int  cyc;
  int  wr_seen;
  int  done_cyc;
  int  coll_seen;
  int  n_chk;
  int  n_pass;

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, e);
  endtask

  // Expected writes, collision and cycle count from the DXYN rules
  task automatic plan(input int x, input int y, input int n, input int ia);
    int x0, y0, set, px, py;
    bit ok;
    bit [7:0] b;
    x0 = x % 64;
    y0 = y % 32;
    set = 0;
    exp_coll = 0;
    for (int r = 0; r < n; r++) begin
      b = mem[(ia + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          ok = 1'b1;
`ifdef CHIP8_SPRITE_CLIP_EN
          ok = (x0 + c < 64) && (y0 + r < 32);
`endif
          if (ok) begin
            px = (x0 + c) % 64;
            py = (y0 + r) % 32;
            if (ref_fb[py][px]) exp_coll = 1;
            q.push_back('{px, py, ref_fb[py][px] ? 0 : 1});
            ref_fb[py][px] = ~ref_fb[py][px];
            set++;
          end
        end
      end
    end
    exp_writes = set;
    exp_cycles = n * (ML + 1 + 8) + set * FL + 1;
  endtask

  task automatic draw(input int x, input int y, input int n, input int ia);
    plan(x, y, n, ia);
    @(negedge clk);
    x_in   = 8'(x);
    y_in   = 8'(y);
    n_in   = 4'(n);
    i_addr = 12'(ia);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 0;
    wr_seen = 0;
    act     = 1'b1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (act && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (act) begin
      chk("done_timeout", 0, 1);
      act = 1'b0;
      q.delete();
    end
  endtask

  task automatic fb_check(input string nm);
    int diff;
    diff = 0;
    @(negedge clk);
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 64; xx++)
        if (fbm[yy][xx] != ref_fb[yy][xx]) diff++;
    chk(nm, diff, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_fb_x"}, fb_addr_x, 0);
    chk({tag, "_fb_y"}, fb_addr_y, 0);
    chk({tag, "_fb_wd"}, fb_writedata, 0);
    chk({tag, "_fb_we"}, fb_WE, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_coll"}, collision, 0);
  endtask

  // Per-cycle compare of writes, busy and completion against the model
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (act) cyc++;
        chk("busy", busy, act);
        if (fb_WE) begin
          wr_seen++;
          if (q.size() == 0) begin
            chk("unexpected_we", fb_WE, 0);
          end else begin
            e = q.pop_front();
            chk("wr_x", fb_addr_x, e.x);
            chk("wr_y", fb_addr_y, e.y);
            chk("wr_data", fb_writedata, e.d);
          end
        end
        if (done) begin
          chk("done_expected", act, 1);
          chk("done_cycle", cyc, exp_cycles);
          chk("collision", collision, exp_coll);
          chk("pending_writes", q.size(), 0);
          done_cyc  = cyc;
          coll_seen = collision;
          act       = 1'b0;
        end
      end
    end
  end

  initial begin
    int planned, t, rx, ry, rn, ria;
    wr_t e;
    n_chk = 0; n_pass = 0; act = 0; mon_en = 0; cyc = 0;
    reset = 1'b1; start = 1'b0;
    x_in = '0; y_in = '0; n_in = '0; i_addr = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
    mem[12'h300] = 8'hFF; mem[12'h301] = 8'hFF;
    mem[12'h123] = 8'h81;
    for (int a = 0; a < 5; a++) mem[12'h400 + a] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Font "0" at origin on a clear screen
    draw(0, 0, 5, 'h050);
    wait_done();
    chk("t1_writes", wr_seen, 14);
    chk("t1_cycles", done_cyc, 65);
    chk("t1_coll", coll_seen, 0);
    fb_check("t1_fb");
    chk("t1_p00", fbm[0][0], 1);
    chk("t1_p30", fbm[0][3], 1);
    chk("t1_p01", fbm[1][0], 1);
    chk("t1_p11", fbm[1][1], 0);
    chk("t1_p34", fbm[4][3], 1);

    // Same draw erases it and collides
    draw(0, 0, 5, 'h050);
    wait_done();
    chk("t2_writes", wr_seen, 14);
    chk("t2_coll", coll_seen, 1);
    fb_check("t2_fb");
    chk("t2_p00", fbm[0][0], 0);

    // Corner wrap
    draw(62, 31, 2, 'h300);
    wait_done();
`ifdef CHIP8_SPRITE_CLIP_EN
    chk("t3_writes", wr_seen, 2);
    chk("t3_p5_0", fbm[0][5], 0);
`else
    chk("t3_writes", wr_seen, 16);
    chk("t3_p5_0", fbm[0][5], 1);
`endif
    chk("t3_p62_31", fbm[31][62], 1);
    chk("t3_p63_31", fbm[31][63], 1);
    fb_check("t3_fb");

    // Start coordinate wrap (200,40) -> (8,8)
    draw(200, 40, 1, 'h123);
    wait_done();
    chk("t4_writes", wr_seen, 2);
    chk("t4_p8", fbm[8][8], 1);
    chk("t4_p15", fbm[8][15], 1);
    chk("t4_p9", fbm[8][9], 0);
    chk("t4_mem_addr", mem_addr, 'h123);

    // Zero-height sprite
    draw(5, 5, 0, 'h200);
    wait_done();
    chk("t5_cycles", done_cyc, 1);
    chk("t5_writes", wr_seen, 0);
    chk("t5_coll", coll_seen, 0);
    chk("t5_mem_addr", mem_addr, 'h123);

    // Start pulse during a 15-row draw is ignored
    draw(33, 17, 15, 'h700);
    planned = exp_writes;
    repeat (40) @(posedge clk);
    @(negedge clk);
    x_in = 8'd1; y_in = 8'd2; n_in = 4'd3; i_addr = 12'h050;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("t6_writes", wr_seen, planned);
    fb_check("t6_fb");

    // Reset during a row-2 write
    draw(20, 10, 5, 'h400);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(fb_WE && fb_addr_y == 5'd12) && t < 500);
    chk("t7_reached_row2", fb_addr_y, 12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    act   = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_back();
      ref_fb[e.y][e.x] = ~ref_fb[e.y][e.x];
    end
    @(negedge clk);
    chk_zero_outputs("t7");
    repeat (20) @(posedge clk);
    fb_check("t7_fb");

    // Random draws, including a 12-bit address wrap
    draw(100, 7, 3, 'hFFF);
    wait_done();
    fb_check("wrap_fb");
    for (int k = 0; k < 12; k++) begin
      rx  = $urandom_range(0, 255);
      ry  = $urandom_range(0, 255);
      rn  = $urandom_range(1, 15);
      ria = $urandom_range(0, 4095);
      draw(rx, ry, rn, ria);
      wait_done();
      fb_check("rand_fb");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
